// File: rtl/brisc_pkg.sv
// brisc shared types and constants used across the pipeline stages.
// Fetch additions: icache FSM states, NOP encoding, icache geometry defaults.
package brisc_pkg;

    localparam int XLEN     = 32;
    localparam int REG_BITS = 5;

    typedef enum logic {
        PC_SEQ,
        FROM_A
    } pc_src_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } icache_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int ICACHE_NUM_LINES  = 4;
    localparam int ICACHE_LINE_BYTES = 16;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped icache storage: tag/valid/data arrays,
// combinational lookup and single-line synchronous refill write.
module icache_array
    import brisc_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_LINES  = ICACHE_NUM_LINES,
    parameter int LINE_BYTES = ICACHE_LINE_BYTES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [XLEN-1:0]         rd_addr_i,
    output logic                    hit_o,
    output logic [31:0]             rd_word_o,
    input  logic                    wr_en_i,
    input  logic [XLEN-1:0]         wr_addr_i,
    input  logic [LINE_BYTES*8-1:0] wr_line_i
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = XLEN - OFF_W - IDX_W;
    localparam int WSEL_W = (OFF_W > 2) ? OFF_W - 2 : 1;

    logic [NUM_LINES-1:0]    valid_q;
    logic [TAG_W-1:0]        tag_q  [NUM_LINES];
    logic [LINE_BYTES*8-1:0] data_q [NUM_LINES];

    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [TAG_W-1:0]  rd_tag;
    logic [TAG_W-1:0]  wr_tag;
    logic [WSEL_W-1:0] wsel;
    logic              unused_ok;

    assign rd_idx = rd_addr_i[OFF_W +: IDX_W];
    assign rd_tag = rd_addr_i[XLEN-1 -: TAG_W];
    assign wr_idx = wr_addr_i[OFF_W +: IDX_W];
    assign wr_tag = wr_addr_i[XLEN-1 -: TAG_W];

    // single-word lines have no word-select bits
    generate
        if (OFF_W > 2) begin : g_wsel
            assign wsel = rd_addr_i[OFF_W-1:2];
        end else begin : g_wsel_none
            assign wsel = '0;
        end
    endgenerate

    assign unused_ok = ^{rd_addr_i[1:0], wr_addr_i[OFF_W-1:0]};

    assign hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_word_o = data_q[rd_idx][{wsel, 5'b0} +: 32];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_line_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, icache refill FSM and A-stage redirect handling.
// Define ICACHE_STATS_EN to add saturating hit/miss counters.
module fetch_unit
    import brisc_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_1000,
    parameter int              NUM_LINES  = ICACHE_NUM_LINES,
    parameter int              LINE_BYTES = ICACHE_LINE_BYTES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_F_in,
    input  pc_src_e                 pc_src_in,
    input  logic [XLEN-1:0]         pc_target_in,
    output logic [XLEN-1:0]         pc_out,
    output logic [31:0]             instr_out,
    output logic                    icache_busy_out,
    output logic                    mem_req_out,
    output logic [XLEN-1:0]         mem_addr_out,
    input  logic                    mem_ready_in,
    input  logic [LINE_BYTES*8-1:0] mem_data_in
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]             hit_count_out,
    output logic [31:0]             miss_count_out
`endif
);

    localparam int OFF_W = $clog2(LINE_BYTES);

    icache_state_e   state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            pend_vld_q, pend_vld_d;

    logic            hit;
    logic [31:0]     word;
    logic            redirect;
    logic            refill_done;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] line_addr;
    logic            unused_ok;

    assign redirect    = (pc_src_in == FROM_A);
    assign target      = {pc_target_in[XLEN-1:2], 2'b00};
    assign line_addr   = {pc_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign refill_done = (state_q == WAIT) && mem_ready_in;
    assign unused_ok   = ^pc_target_in[1:0];

    // refill writes use the latched request address, not the live PC
    icache_array #(
        .XLEN       (XLEN),
        .NUM_LINES  (NUM_LINES),
        .LINE_BYTES (LINE_BYTES)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_i (pc_q),
        .hit_o     (hit),
        .rd_word_o (word),
        .wr_en_i   (refill_done && !reset),
        .wr_addr_i (addr_q),
        .wr_line_i (mem_data_in)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        unique case (state_q)
            IDLE: begin
                // a redirect re-looks-up next cycle instead of refilling a stale PC
                if (redirect) begin
                    pc_d = target;
                end else if (!hit) begin
                    state_d = REQ;
                    addr_d  = line_addr;
                end else if (!stall_F_in) begin
                    pc_d = pc_q + XLEN'(4);
                end
            end
            REQ: begin
                state_d = WAIT;
                if (redirect) begin
                    pend_d     = target;
                    pend_vld_d = 1'b1;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pend_d     = target;
                    pend_vld_d = 1'b1;
                end
                if (mem_ready_in) begin
                    state_d    = IDLE;
                    pend_vld_d = 1'b0;
                    if (redirect) begin
                        pc_d = target;
                    end else if (pend_vld_q) begin
                        pc_d = pend_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign pc_out          = pc_q;
    assign mem_req_out     = (state_q == REQ);
    assign mem_addr_out    = addr_q;
    assign icache_busy_out = (state_q != IDLE) || !hit;
    assign instr_out       = ((state_q == IDLE) && hit) ? word : NOP_INSTR;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if ((state_q == IDLE) && hit && !stall_F_in && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if ((state_q == IDLE) && (state_d == REQ) && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count_out  = hit_cnt_q;
    assign miss_count_out = miss_cnt_q;
`endif

endmodule
